// File: rtl/control_fsm_if.sv
// Memory request/response bus between the sequencer and instruction/data memory.
// A request (rd or wr) is held stable until the posedge where ready is 1.
interface control_fsm_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle fetch/execute sequencer: owns PC, IR and flags, drives the register
// file selects and write port, and issues fetch/LOAD/STOR requests on the memory bus.
module control_fsm (
    input  logic               clk,
    input  logic               rst_n,
    control_fsm_if.master      mem,
    output logic [4:0]         register1,
    output logic [4:0]         register2,
    output logic [15:0]        data_in,
    output logic               write,
    input  logic [15:0]        r1_data_out,
    input  logic [15:0]        r2_data_out,
    output logic [15:0]        pc_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        MEM   = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ext;
    logic [3:0]  rs;
    logic [15:0] disp;
    logic [15:0] result;
    logic        writes_reg;
    logic        is_cmp;
    logic        is_load;
    logic        is_stor;
    logic        is_jump;
    logic        is_branch;
    logic        take_branch;

    assign op     = ir[15:12];
    assign rd     = ir[11:8];
    assign ext    = ir[7:4];
    assign rs     = ir[3:0];
    assign disp   = {{8{ir[7]}}, ir[7:0]};
    assign pc_out = pc;

    assign is_cmp    = (op == 4'h0) && (ext == 4'hB);
    assign is_load   = (op == 4'h4) && (ext == 4'h0);
    assign is_stor   = (op == 4'h4) && (ext == 4'h4);
    assign is_jump   = (op == 4'h4) && (ext == 4'hC);
    assign is_branch = (op == 4'hC);

    always_comb begin
        result     = 16'h0000;
        writes_reg = 1'b0;
        if (op == 4'h5) begin
            result     = r1_data_out + disp;
            writes_reg = 1'b1;
        end else if (op == 4'hD) begin
            result     = {8'h00, ir[7:0]};
            writes_reg = 1'b1;
        end else if (op == 4'h0) begin
            writes_reg = 1'b1;
            case (ext)
                4'h1:    result = r1_data_out & r2_data_out;
                4'h2:    result = r1_data_out | r2_data_out;
                4'h3:    result = r1_data_out ^ r2_data_out;
                4'h5:    result = r1_data_out + r2_data_out;
                4'h9:    result = r1_data_out - r2_data_out;
                4'hD:    result = r2_data_out;
                default: writes_reg = 1'b0;
            endcase
        end
    end

    // The rd field doubles as the branch condition code.
    always_comb begin
        case (rd)
            4'h0:    take_branch = flag_z;
            4'h1:    take_branch = !flag_z;
            4'h2:    take_branch = flag_c;
            4'h3:    take_branch = !flag_c;
            4'h4:    take_branch = flag_n;
            4'h5:    take_branch = !flag_n;
            4'hE:    take_branch = 1'b1;
            default: take_branch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   if (mem.mem_ready) next_state = EXEC;
            EXEC:    next_state = (is_load || is_stor) ? MEM : FETCH;
            MEM:     if (mem.mem_ready) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Branch displacement is applied to the PC already incremented during FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= 16'h0000;
            ir     <= 16'h0000;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem.mem_ready) begin
                        ir <= mem.mem_rdata;
                        pc <= pc + 16'd1;
                    end
                end
                EXEC: begin
                    if (is_cmp) begin
                        flag_z <= (r1_data_out == r2_data_out);
                        flag_c <= (r1_data_out < r2_data_out);
                        flag_n <= ($signed(r1_data_out) < $signed(r2_data_out));
                    end
                    if (is_jump) begin
                        pc <= r2_data_out;
                    end else if (is_branch && take_branch) begin
                        pc <= pc + disp;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem.mem_addr  = 16'h0000;
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_wdata = 16'h0000;
        register1     = 5'd0;
        register2     = 5'd0;
        data_in       = 16'h0000;
        write         = 1'b0;
        case (state)
            FETCH: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = pc;
            end
            EXEC: begin
                register1 = {1'b0, rd};
                register2 = {1'b0, rs};
                data_in   = result;
                write     = writes_reg && (rd != 4'h0);
            end
            MEM: begin
                register1    = {1'b0, rd};
                register2    = {1'b0, rs};
                mem.mem_addr = r2_data_out;
                if (is_load) begin
                    mem.mem_rd = 1'b1;
                    data_in    = mem.mem_rdata;
                    write      = mem.mem_ready && (rd != 4'h0);
                end else begin
                    mem.mem_wr    = 1'b1;
                    mem.mem_wdata = r1_data_out;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: table of single instructions plus
// hand-written LOAD/STOR/reset sequences, with a scoreboard on register-file writes and stores.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  register1;
    logic [4:0]  register2;
    logic [15:0] data_in;
    logic        write;
    logic [15:0] r1_data_out;
    logic [15:0] r2_data_out;
    logic [15:0] pc_out;

    control_fsm_if bus ();

    control_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (bus),
        .register1   (register1),
        .register2   (register2),
        .data_in     (data_in),
        .write       (write),
        .r1_data_out (r1_data_out),
        .r2_data_out (r2_data_out),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] r1;
        logic [15:0] r2;
        logic        exp_write;
        logic [15:0] exp_data;
        logic [15:0] next_pc;
    } vec_t;

    vec_t        vec[$];
    logic [20:0] wr_q[$];
    logic [31:0] st_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_pc;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] r1, input logic [15:0] r2);
        bus.mem_rdata = instr;
        bus.mem_ready = 1'b1;
        r1_data_out   = r1;
        r2_data_out   = r2;
    endtask

    function automatic void addVec(input logic [15:0] instr, input logic [15:0] r1, input logic [15:0] r2,
                                   input logic w, input logic [15:0] d, input logic [15:0] npc);
        vec_t v;
        v.instr = instr; v.r1 = r1; v.r2 = r2;
        v.exp_write = w; v.exp_data = d; v.next_pc = npc;
        vec.push_back(v);
    endfunction

    task automatic checkFetch(input string name, input logic [15:0] addr);
        checkOutput(name, {bus.mem_rd, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b0, addr});
    endtask

    // Scoreboard: every register write and completed store must match the head of its queue.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (write === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got reg %0d data %h, expected no write", register1, data_in);
                end else begin
                    checkOutput("reg_write", {register1, data_in}, wr_q.pop_front());
                end
            end
            if (bus.mem_wr === 1'b1 && bus.mem_ready === 1'b1) begin
                if (st_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_store: got addr %h data %h, expected no store", bus.mem_addr, bus.mem_wdata);
                end else begin
                    checkOutput("mem_store", {bus.mem_addr, bus.mem_wdata}, st_q.pop_front());
                end
            end
        end
    end

    initial begin
        // addr 0..12: ALU / immediate / suppressed-R0 / CMP equal
        addVec(16'hD17F, 16'h0000, 16'h0000, 1'b1, 16'h007F, 16'h0001);
        addVec(16'h0152, 16'hFFFF, 16'h0002, 1'b1, 16'h0001, 16'h0002);
        addVec(16'h0213, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 16'h0003);
        addVec(16'h0223, 16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 16'h0004);
        addVec(16'h0233, 16'hF0F0, 16'h3C3C, 1'b1, 16'hCCCC, 16'h0005);
        addVec(16'h0293, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'h0006);
        addVec(16'h02D3, 16'h1111, 16'hABCD, 1'b1, 16'hABCD, 16'h0007);
        addVec(16'h5280, 16'h0005, 16'h0000, 1'b1, 16'hFF85, 16'h0008);
        addVec(16'h5401, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0009);
        addVec(16'hD0AA, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h000A);
        addVec(16'h0F0F, 16'h1234, 16'h5678, 1'b0, 16'h0000, 16'h000B);
        addVec(16'h0017, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h000C);
        addVec(16'h01B2, 16'h0005, 16'h0005, 1'b0, 16'h0000, 16'h000D);
        // jump and branches on Z=1, then CMP 3 vs 5 (Z0 C1 N1)
        addVec(16'h40C2, 16'h0000, 16'h0005, 1'b0, 16'h0000, 16'h0005);
        addVec(16'hC0FE, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0004);
        addVec(16'hC1FE, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0005);
        addVec(16'hC2FE, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0006);
        addVec(16'h01B2, 16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h0007);
        addVec(16'hC203, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h000B);
        addVec(16'hC503, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h000C);
        addVec(16'hC4F0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hFFFD);
        // CMP 0x8000 vs 1 (Z0 C0 N1), never-taken cond, PC wrap, always, HS, EQ, NE
        addVec(16'h01B2, 16'h8000, 16'h0001, 1'b0, 16'h0000, 16'hFFFE);
        addVec(16'hC605, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hFFFF);
        addVec(16'hF000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        addVec(16'hCE02, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0003);
        addVec(16'hC301, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0005);
        addVec(16'hC0FE, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0006);
        addVec(16'hC102, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0009);

        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        r1_data_out   = 16'h0000;
        r2_data_out   = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_bus", {bus.mem_rd, bus.mem_wr, write, bus.mem_addr, bus.mem_wdata}, 64'd0);
        checkOutput("reset_regs", {register1, register2, data_in, pc_out}, 64'd0);

        rst_n = 1'b1;
        checkOutput("idle_no_req", {bus.mem_rd, bus.mem_wr}, 64'd0);
        @(negedge clk);
        exp_pc = 16'h0000;

        for (int i = 0; i < vec.size(); i++) begin
            checkFetch($sformatf("fetch_addr[%0d]", i), exp_pc);
            if (vec[i].exp_write) wr_q.push_back({1'b0, vec[i].instr[11:8], vec[i].exp_data});
            applyStimulus(vec[i].instr, vec[i].r1, vec[i].r2);
            @(negedge clk);
            checkOutput($sformatf("exec_sel[%0d]", i),
                        {bus.mem_rd, bus.mem_wr, register1, register2, pc_out},
                        {2'b00, 1'b0, vec[i].instr[11:8], 1'b0, vec[i].instr[3:0], exp_pc + 16'd1});
            exp_pc = vec[i].next_pc;
            @(negedge clk);
        end

        // LOAD R3,R4 with three wait cycles
        checkFetch("load_fetch", exp_pc);
        applyStimulus(16'h4304, 16'h0000, 16'h1234);
        @(negedge clk);
        checkOutput("load_exec", {bus.mem_rd, bus.mem_wr, write}, 64'd0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'hDEAD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("load_wait[%0d]", k),
                        {bus.mem_rd, bus.mem_wr, bus.mem_addr, register1}, {1'b1, 1'b0, 16'h1234, 5'd3});
            if (k == 3) begin
                wr_q.push_back({5'd3, 16'h5A5A});
                bus.mem_rdata = 16'h5A5A;
                bus.mem_ready = 1'b1;
            end
        end
        exp_pc = exp_pc + 16'd1;
        @(negedge clk);

        // STOR R1,R2 with one wait cycle
        checkFetch("stor_fetch", exp_pc);
        applyStimulus(16'h4142, 16'hBEEF, 16'h0040);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("stor_wait", {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                    {1'b0, 1'b1, 16'h0040, 16'hBEEF});
        @(negedge clk);
        checkOutput("stor_hold", {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                    {1'b0, 1'b1, 16'h0040, 16'hBEEF});
        st_q.push_back({16'h0040, 16'hBEEF});
        bus.mem_ready = 1'b1;
        exp_pc = exp_pc + 16'd1;
        @(negedge clk);

        // Reset pulsed during a LOAD wait
        checkFetch("rst_load_fetch", exp_pc);
        applyStimulus(16'h4304, 16'h0000, 16'h2222);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_load_req", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h2222});
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_drop", {bus.mem_rd, bus.mem_wr, write, pc_out, bus.mem_addr}, 64'd0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        rst_n = 1'b1;
        checkOutput("rst_idle", {bus.mem_rd, bus.mem_wr}, 64'd0);
        @(negedge clk);
        checkFetch("rst_refetch", 16'h0000);
        @(negedge clk);

        checkOutput("wr_queue_empty", wr_q.size(), 64'd0);
        checkOutput("st_queue_empty", st_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
